dwconv_tap_accumulator: RTL and testbench

Depthwise-convolution accumulation stage directly downstream of the convolution activation stage. Each beat it takes 16 signed 8-bit activations, the 9 depthwise weights selected for the current channel, and the channel/tap tags (`cnt`, `pos`). Over the 9 taps of one channel group it multiply-accumulates per lane. It then emits 16 signed 32-bit sums tagged with the channel, ready for the next rescale/ReLU stage. The pipeline enable `en` is shared with the neighbouring stages; there is no back-pressure.

---
 rtl/dwconv_tap_accumulator.sv | 143 ++++++++++++++
 tb/tb_dwconv_tap_accumulator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwconv_tap_accumulator.sv
// Depthwise-convolution tap accumulator: 16 lanes of signed 8x8 products summed
// over the 9 taps of a channel group, emitted as 32-bit sums tagged with the channel.
module dwconv_tap_accumulator (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [127:0] act_in,
    input  logic [71:0]  dw_weight,
    input  logic [4:0]   cnt_in,
    input  logic [3:0]   pos_in,
    output logic [511:0] out_data,
    output logic         out_valid,
    output logic [4:0]   cnt_out,
    output logic         err
);

    localparam int unsigned LANES    = 16;
    localparam int unsigned TAPS     = 9;
    localparam int unsigned AW       = 8;
    localparam int unsigned PW       = 16;
    localparam int unsigned SW       = 32;
    localparam int unsigned CW       = 5;
    localparam int unsigned POSW     = 4;
    localparam int unsigned LAST_POS = 8;

    logic signed [AW-1:0]   w_sel_c;
    logic signed [PW-1:0]   prod_c   [LANES];

    logic                   s1_valid;
    logic signed [PW-1:0]   s1_prod  [LANES];
    logic [POSW-1:0]        s1_pos;
    logic [CW-1:0]          s1_cnt;

    logic signed [SW-1:0]   acc_q    [LANES];
    logic signed [SW-1:0]   acc_d    [LANES];
    logic signed [SW-1:0]   sum_c    [LANES];
    logic [POSW-1:0]        exp_pos_q;
    logic [POSW-1:0]        exp_pos_d;
    logic [CW-1:0]          grp_cnt_q;
    logic [CW-1:0]          grp_cnt_d;
    logic [LANES*SW-1:0]    out_data_d;
    logic                   out_valid_d;
    logic [CW-1:0]          cnt_out_d;
    logic                   err_d;

    // Weight mux; out-of-range taps select zero (such beats are dropped later anyway)
    always_comb begin
        w_sel_c = '0;
        for (int t = 0; t < TAPS; t++) begin
            if (pos_in == POSW'(t)) begin
                w_sel_c = dw_weight[AW*t +: AW];
            end
        end
        for (int j = 0; j < LANES; j++) begin
            prod_c[j] = PW'($signed(act_in[AW*j +: AW])) * PW'(w_sel_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pos   <= '0;
            s1_cnt   <= '0;
            for (int j = 0; j < LANES; j++) begin
                s1_prod[j] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pos <= pos_in;
                s1_cnt <= cnt_in;
                for (int j = 0; j < LANES; j++) begin
                    s1_prod[j] <= prod_c[j];
                end
            end
        end
    end

    // Tap sequencer: exp_pos is the next tap expected within the current group
    always_comb begin
        exp_pos_d   = exp_pos_q;
        grp_cnt_d   = grp_cnt_q;
        err_d       = err;
        out_valid_d = 1'b0;
        out_data_d  = out_data;
        cnt_out_d   = cnt_out;
        for (int j = 0; j < LANES; j++) begin
            sum_c[j] = acc_q[j] + SW'(s1_prod[j]);
            acc_d[j] = acc_q[j];
        end
        if (s1_valid) begin
            if (s1_pos == '0) begin
                err_d     = err | (exp_pos_q != '0);
                grp_cnt_d = s1_cnt;
                exp_pos_d = POSW'(1);
                for (int j = 0; j < LANES; j++) begin
                    acc_d[j] = SW'(s1_prod[j]);
                end
            end else if ((s1_pos == exp_pos_q) && (s1_pos < POSW'(LAST_POS))) begin
                exp_pos_d = POSW'(exp_pos_q + POSW'(1));
                for (int j = 0; j < LANES; j++) begin
                    acc_d[j] = sum_c[j];
                end
            end else if ((s1_pos == POSW'(LAST_POS)) && (exp_pos_q == POSW'(LAST_POS))) begin
                exp_pos_d   = '0;
                cnt_out_d   = grp_cnt_q;
                out_valid_d = 1'b1;
                for (int j = 0; j < LANES; j++) begin
                    out_data_d[SW*j +: SW] = sum_c[j];
                    acc_d[j]               = '0;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_pos_q <= '0;
            grp_cnt_q <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            cnt_out   <= '0;
            err       <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                acc_q[j] <= '0;
            end
        end else if (en) begin
            exp_pos_q <= exp_pos_d;
            grp_cnt_q <= grp_cnt_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            cnt_out   <= cnt_out_d;
            err       <= err_d;
            for (int j = 0; j < LANES; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

endmodule

// File: tb/tb_dwconv_tap_accumulator.sv
// Self-checking bench for dwconv_tap_accumulator: directed scenarios plus random
// groups, compared against a beat-level integer reference model.
module tb_dwconv_tap_accumulator;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         in_valid;
    logic [127:0] act_in;
    logic [71:0]  dw_weight;
    logic [4:0]   cnt_in;
    logic [3:0]   pos_in;
    logic [511:0] out_data;
    logic         out_valid;
    logic [4:0]   cnt_out;
    logic         err;

    always #5 clk = ~clk;

    dwconv_tap_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .act_in    (act_in),
        .dw_weight (dw_weight),
        .cnt_in    (cnt_in),
        .pos_in    (pos_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .cnt_out   (cnt_out),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: integer sums per lane, updated once per accepted beat
    typedef struct {
        logic [511:0] data;
        logic [4:0]   cnt;
    } res_t;

    res_t       exp_q[$];
    int         m_exp_pos = 0;
    bit         m_err = 1'b0;
    int         m_acc[16];
    logic [4:0] m_grp = '0;
    int         exp_pulses = 0;
    int         seen_pulses = 0;

    function automatic int act_of(input logic [127:0] a, input int j);
        logic signed [7:0] b;
        b = a[8*j +: 8];
        return int'(b);
    endfunction

    task automatic model_beat(input logic [127:0] a, input logic [71:0] w,
                              input logic [4:0] c, input int p);
        logic signed [7:0] wb;
        int   wt;
        res_t r;
        if (p > 8) begin
            m_err = 1'b1;
            return;
        end
        wb = w[8*p +: 8];
        wt = int'(wb);
        if (p == 0) begin
            if (m_exp_pos != 0) m_err = 1'b1;
            for (int j = 0; j < 16; j++) m_acc[j] = act_of(a, j) * wt;
            m_grp     = c;
            m_exp_pos = 1;
        end else if (p == m_exp_pos && p < 8) begin
            for (int j = 0; j < 16; j++) m_acc[j] += act_of(a, j) * wt;
            m_exp_pos++;
        end else if (p == 8 && m_exp_pos == 8) begin
            for (int j = 0; j < 16; j++) r.data[32*j +: 32] = 32'(m_acc[j] + act_of(a, j) * wt);
            r.cnt = m_grp;
            exp_q.push_back(r);
            exp_pulses++;
            m_exp_pos = 0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [71:0] rand72();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    // One clock: inputs applied 1 time unit after the previous rising edge
    task automatic step(input bit v, input logic [127:0] a, input logic [71:0] w,
                        input logic [4:0] c, input logic [3:0] p);
        in_valid  = v;
        act_in    = a;
        dw_weight = w;
        cnt_in    = c;
        pos_in    = p;
        if (!rst && en && v) model_beat(a, w, c, int'(p));
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] c, input int p, input logic [127:0] a, input logic [71:0] w);
        step(1'b1, a, w, c, 4'(p));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rand128(), rand72(), 5'($urandom), 4'($urandom));
    endtask

    task automatic stall(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) step(1'($urandom), rand128(), rand72(), 5'($urandom), 4'($urandom));
        en = 1'b1;
    endtask

    task automatic rand_group(input logic [4:0] c, input bit bubbles);
        for (int p = 0; p < 9; p++) begin
            beat(c, p, rand128(), rand72());
            if (bubbles) idle(1);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge
    logic         edge_en = 1'b0;
    logic         edge_rst = 1'b1;
    logic         prev_ov = 1'b0;
    logic [511:0] prev_data = '0;
    logic [4:0]   prev_cnt = '0;
    logic [511:0] last_data = '0;

    always @(posedge clk) begin
        edge_en  <= en;
        edge_rst <= rst;
    end

    always @(negedge clk) begin
        res_t r;
        if (!edge_rst && !edge_en) begin
            check("hold_valid", 64'(out_valid), 64'(prev_ov));
            check("hold_data", 64'(out_data != prev_data), 64'd0);
            check("hold_cnt", 64'(cnt_out), 64'(prev_cnt));
        end else if (!edge_rst && out_valid) begin
            seen_pulses++;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                r = exp_q.pop_front();
                for (int j = 0; j < 16; j++)
                    check($sformatf("lane%0d", j), 64'(out_data[32*j +: 32]), 64'(r.data[32*j +: 32]));
                check("cnt_out", 64'(cnt_out), 64'(r.cnt));
            end
            last_data = out_data;
        end
        prev_ov   = out_valid;
        prev_data = out_data;
        prev_cnt  = cnt_out;
    end

    logic [127:0] a_ext;
    int           pulses_before;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        in_valid = 1'b0;
        act_in = '0;
        dw_weight = '0;
        cnt_in = '0;
        pos_in = '0;

        // Reset with en low: reset must still win
        idle(3);
        check("rst_data", 64'(out_data != '0), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_cnt", 64'(cnt_out), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        en  = 1'b1;
        idle(1);

        // Single group: act 3, weights 1..9
        pulses_before = seen_pulses;
        for (int p = 0; p < 9; p++)
            beat(5'd5, p, {16{8'd3}}, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        idle(3);
        check("single_lane0", 64'(last_data[31:0]), 64'd135);
        check("single_lane15", 64'(last_data[511:480]), 64'd135);
        check("single_pulses", 64'(seen_pulses - pulses_before), 64'd1);
        check("single_err", 64'(err), 64'd0);
        check("single_valid_low", 64'(out_valid), 64'd0);

        // Signed extremes
        for (int p = 0; p < 9; p++) begin
            a_ext = rand128();
            a_ext[15:0] = 16'h7f80;
            beat(5'd17, p, a_ext, {9{8'h80}});
        end
        idle(3);
        check("ext_lane0", 64'(last_data[31:0]), 64'd147456);
        check("ext_lane1", 64'(last_data[63:32]), 64'h00000000FFFDC480);

        // Back-to-back groups with stalls mid-group and on the output cycle
        pulses_before = seen_pulses;
        for (int p = 0; p < 4; p++) beat(5'd1, p, rand128(), rand72());
        stall(3);
        for (int p = 4; p < 9; p++) beat(5'd1, p, rand128(), rand72());
        beat(5'd2, 0, rand128(), rand72());
        check("b2b_valid_out", 64'(out_valid), 64'd1);
        stall(3);
        for (int p = 1; p < 9; p++) beat(5'd2, p, rand128(), rand72());
        stall(3);
        idle(3);
        check("b2b_pulses", 64'(seen_pulses - pulses_before), 64'd2);
        check("b2b_err", 64'(err), 64'd0);

        // Sequence errors: dropped pos 3, then early restart
        beat(5'd9, 0, rand128(), rand72());
        beat(5'd9, 1, rand128(), rand72());
        beat(5'd9, 3, rand128(), rand72());
        for (int p = 2; p < 9; p++) beat(5'd9, p, rand128(), rand72());
        idle(2);
        check("seq_err_set", 64'(err), 64'd1);
        for (int p = 0; p < 3; p++) beat(5'd10, p, rand128(), rand72());
        rand_group(5'd11, 1'b0);
        idle(3);
        check("seq_err_model", 64'(err), 64'(m_err));
        check("seq_err_sticky", 64'(err), 64'd1);

        // Bubbles between every beat
        pulses_before = seen_pulses;
        rand_group(5'd20, 1'b1);
        rand_group(5'd21, 1'b1);
        idle(3);
        check("bubble_pulses", 64'(seen_pulses - pulses_before), 64'd2);

        // Reset mid-group clears everything including err
        for (int p = 0; p < 5; p++) beat(5'd30, p, rand128(), rand72());
        rst = 1'b1;
        idle(1);
        check("midrst_data", 64'(out_data != '0), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_cnt", 64'(cnt_out), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        idle(1);
        rst = 1'b0;
        m_exp_pos = 0;
        m_err = 1'b0;
        rand_group(5'd31, 1'b0);
        idle(3);
        check("midrst_err_after", 64'(err), 64'd0);

        // Random groups with random bubbles and stalls
        for (int g = 0; g < 15; g++) begin
            for (int p = 0; p < 9; p++) begin
                beat(5'($urandom), p, rand128(), rand72());
                case ($urandom_range(0, 3))
                    0: idle(1);
                    1: stall($urandom_range(1, 3));
                    default: ;
                endcase
            end
        end
        idle(4);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_pulses", 64'(seen_pulses), 64'(exp_pulses));
        check("final_err", 64'(err), 64'(m_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
